// File: rtl/fifo_window_ctrl.sv
// fifo_window_ctrl: streams one IFM channel from the IFM RAM into the 5x5
// window shift-register FIFO in raster order, flags the cycles where the FIFO
// taps hold a legal window, and tags each window with its OFM address.
// Backpressure from the convolution datapath is absorbed by a one-entry hold
// (skid) register so no pixel is lost or duplicated across a stall.
// Optional feature macro: FIFO_CTRL_STALL_CNT_EN adds a 16-bit saturating
// per-frame stall cycle counter on output stall_count.
module fifo_window_ctrl #(
    parameter int DATA_WIDTH            = 32,
    parameter int IFM_SIZE              = 32,
    parameter int KERNAL_SIZE           = 5,
    parameter int IFM_SIZE_NEXT         = IFM_SIZE - KERNAL_SIZE + 1,
    parameter int ADDRESS_SIZE_IFM      = $clog2(IFM_SIZE * IFM_SIZE),
    parameter int ADDRESS_SIZE_NEXT_IFM = $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT),
    parameter int FIFO_SIZE             = (KERNAL_SIZE - 1) * IFM_SIZE + KERNAL_SIZE
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             conv_ready,
    input  logic [DATA_WIDTH-1:0]            ifm_data_out,
    output logic                             ifm_rd_en,
    output logic [ADDRESS_SIZE_IFM-1:0]      ifm_address,
    output logic                             fifo_enable,
    output logic [DATA_WIDTH-1:0]            fifo_data_in,
    output logic                             window_valid,
    output logic [ADDRESS_SIZE_NEXT_IFM-1:0] ofm_address,
    output logic                             busy,
    output logic                             done
`ifdef FIFO_CTRL_STALL_CNT_EN
    ,
    output logic [15:0]                      stall_count
`endif
);

    localparam int RC_W = $clog2(IFM_SIZE);
    localparam logic [ADDRESS_SIZE_IFM:0] RD_END = (ADDRESS_SIZE_IFM + 1)'(IFM_SIZE * IFM_SIZE);
    localparam logic [ADDRESS_SIZE_IFM:0] RD_ONE = (ADDRESS_SIZE_IFM + 1)'(1);
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(IFM_SIZE - 1);
    localparam logic [RC_W-1:0] RC_KM1  = RC_W'(KERNAL_SIZE - 1);
    localparam logic [RC_W-1:0] RC_ONE  = RC_W'(1);
    localparam logic [ADDRESS_SIZE_NEXT_IFM-1:0] OFM_LAST =
        ADDRESS_SIZE_NEXT_IFM'(IFM_SIZE_NEXT * IFM_SIZE_NEXT - 1);
    localparam logic [ADDRESS_SIZE_NEXT_IFM-1:0] OFM_ONE = ADDRESS_SIZE_NEXT_IFM'(1);

    // The tap geometry fixes FIFO_SIZE; an inconsistent override shows up as
    // this named block in the elaborated hierarchy.
    if (FIFO_SIZE != (KERNAL_SIZE - 1) * IFM_SIZE + KERNAL_SIZE) begin : g_fifo_size_inconsistent
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                             state_r;
    state_t                             state_s;
    logic [ADDRESS_SIZE_IFM:0]          rd_cnt_r;
    logic                               rd_pending_r;
    logic                               hold_valid_r;
    logic [DATA_WIDTH-1:0]              hold_data_r;
    logic [RC_W-1:0]                    row_r;
    logic [RC_W-1:0]                    col_r;
    logic                               window_valid_r;
    logic [ADDRESS_SIZE_NEXT_IFM-1:0]   ofm_r;
    logic                               busy_r;
    logic                               done_r;

    logic stall_s;
    logic rd_en_s;
    logic push_hold_s;
    logic push_ram_s;
    logic push_s;
    logic last_push_s;
    logic start_frame_s;
    logic [DATA_WIDTH-1:0] push_data_s;

    assign stall_s       = window_valid_r & ~conv_ready;
    assign start_frame_s = (state_r == IDLE) & start;
    assign rd_en_s       = (state_r == RUN) & ~stall_s & ~hold_valid_r & (rd_cnt_r < RD_END);
    assign push_s        = push_hold_s | push_ram_s;
    assign last_push_s   = push_s & (row_r == RC_LAST) & (col_r == RC_LAST);

    // Push source select: drain the hold entry first, else the RAM read landing now
    always_comb begin
        push_hold_s = 1'b0;
        push_ram_s  = 1'b0;
        if (!stall_s && hold_valid_r) begin
            push_hold_s = 1'b1;
        end else if (!stall_s && rd_pending_r) begin
            push_ram_s = 1'b1;
        end else begin
            push_hold_s = 1'b0;
            push_ram_s  = 1'b0;
        end
    end

    // Pixel mux toward the FIFO; zero whenever nothing is shifted in
    always_comb begin
        push_data_s = '0;
        if (push_hold_s) begin
            push_data_s = hold_data_r;
        end else if (push_ram_s) begin
            push_data_s = ifm_data_out;
        end else begin
            push_data_s = '0;
        end
    end

    // Frame sequencer next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_s = RUN;
                else       state_s = IDLE;
            end
            RUN: begin
                if (last_push_s) state_s = FLUSH;
                else             state_s = RUN;
            end
            FLUSH: begin
                if (!window_valid_r || conv_ready) state_s = DONE;
                else                               state_s = FLUSH;
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Frame sequencer state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_r <= IDLE;
        else        state_r <= state_s;
    end

    // Read/push counters, hold register, window flag and OFM tag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_cnt_r       <= '0;
            rd_pending_r   <= 1'b0;
            hold_valid_r   <= 1'b0;
            hold_data_r    <= '0;
            row_r          <= '0;
            col_r          <= '0;
            window_valid_r <= 1'b0;
            ofm_r          <= '0;
        end else begin
            rd_pending_r <= rd_en_s;
            if (start_frame_s) begin
                rd_cnt_r       <= '0;
                hold_valid_r   <= 1'b0;
                row_r          <= '0;
                col_r          <= '0;
                window_valid_r <= 1'b0;
                ofm_r          <= '0;
            end else begin
                if (rd_en_s) rd_cnt_r <= rd_cnt_r + RD_ONE;
                if (push_hold_s) begin
                    hold_valid_r <= 1'b0;
                end else if (stall_s && rd_pending_r) begin
                    hold_valid_r <= 1'b1;
                    hold_data_r  <= ifm_data_out;
                end
                if (push_s) begin
                    // Legal window only once a full kernel of rows and columns is in
                    window_valid_r <= (row_r >= RC_KM1) & (col_r >= RC_KM1);
                    if (col_r == RC_LAST) begin
                        col_r <= '0;
                        row_r <= (row_r == RC_LAST) ? '0 : row_r + RC_ONE;
                    end else begin
                        col_r <= col_r + RC_ONE;
                    end
                end else if (conv_ready) begin
                    window_valid_r <= 1'b0;
                end
                // Tag holds the last window index once the frame's final window is taken
                if (window_valid_r && conv_ready && (ofm_r != OFM_LAST)) begin
                    ofm_r <= ofm_r + OFM_ONE;
                end
            end
        end
    end

    // Registered busy/done status
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= (state_r == DONE);
            if (start_frame_s)          busy_r <= 1'b1;
            else if (state_r == DONE)   busy_r <= 1'b0;
        end
    end

`ifdef FIFO_CTRL_STALL_CNT_EN
    logic [15:0] stall_cnt_r;

    // Per-frame saturating stall cycle counter, held after the frame ends
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_r <= 16'd0;
        end else if (start_frame_s) begin
            stall_cnt_r <= 16'd0;
        end else if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
        end
    end

    assign stall_count = stall_cnt_r;
`endif

    assign ifm_rd_en    = rd_en_s;
    assign ifm_address  = rd_cnt_r[ADDRESS_SIZE_IFM-1:0];
    assign fifo_enable  = push_s;
    assign fifo_data_in = push_data_s;
    assign window_valid = window_valid_r;
    assign ofm_address  = ofm_r;
    assign busy         = busy_r;
    assign done         = done_r;

endmodule
